// File: rtl/server_slot_arbiter_pkg.sv
// Shared types and helpers for server_slot_arbiter: occupancy state encoding,
// default sizing and a population count used by the slot counter.
package server_arb_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_SLOTS = 3;

  // Widest supported request vector; narrower vectors are zero-extended.
  localparam int POP_W = 16;

  function automatic logic [4:0] popcount(input logic [POP_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/server_slot_arbiter_if.sv
// Request/grant bundle between student ports and server_slot_arbiter.
// Optional statistics signals exist only when SERVER_ARB_STATS_EN is defined.
interface server_slot_arbiter_if #(
  parameter int NUM_REQ = server_arb_pkg::DEF_NUM_REQ
);
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0] req_conn;
  logic [NUM_REQ-1:0] req_disc;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] connected;
  logic [CNT_W-1:0]   conn_cnt;
  logic               slot_avail;
  logic               full;
`ifdef SERVER_ARB_STATS_EN
  logic [15:0]        deny_cnt;
  logic [CNT_W-1:0]   peak_cnt;
`endif

  modport master (
    output req_conn, req_disc,
    input  gnt, connected, conn_cnt, slot_avail, full
`ifdef SERVER_ARB_STATS_EN
    , input deny_cnt, peak_cnt
`endif
  );

  modport slave (
    input  req_conn, req_disc,
    output gnt, connected, conn_cnt, slot_avail, full
`ifdef SERVER_ARB_STATS_EN
    , output deny_cnt, peak_cnt
`endif
  );

endinterface

// File: rtl/server_slot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward
// from ptr with wrap-around, returned as one-hot, index and valid.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [PTR_W-1:0] win_idx,
  output logic             valid
);

  logic [PTR_W:0] pos;

  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    pos     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      // Extra MSB keeps ptr+off from overflowing before the modulo fold.
      pos = {1'b0, ptr} + (PTR_W+1)'(off);
      if (pos >= (PTR_W+1)'(N)) begin
        pos = pos - (PTR_W+1)'(N);
      end
      if (!valid && req[pos[PTR_W-1:0]]) begin
        valid   = 1'b1;
        win_idx = pos[PTR_W-1:0];
      end
    end
    win[win_idx] = valid;
  end

endmodule

// File: rtl/server_slot_arbiter.sv
// Round-robin connection-slot arbiter for the server front end.
// Define SERVER_ARB_STATS_EN to add the deny_cnt / peak_cnt statistics outputs.
module server_slot_arbiter
  import server_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_SLOTS = DEF_MAX_SLOTS
) (
  input logic                  clk,
  input logic                  rst_n,
  server_slot_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_REQ + 1);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SLOTS);

  logic [NUM_REQ-1:0] connected;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] conn_elig;
  logic [NUM_REQ-1:0] disc_vld;
  logic [NUM_REQ-1:0] win;
  logic [NUM_REQ-1:0] conn_next;
  logic [CNT_W-1:0]   conn_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic               win_vld;
  logic               grant;
  arb_state_e         state;

  function automatic arb_state_e state_of(input logic [CNT_W-1:0] c);
    if (c == '0)      return EMPTY;
    if (c == MAX_CNT) return FULL;
    return PARTIAL;
  endfunction

  // A connected port can only disconnect; an unconnected one can only connect.
  assign conn_elig = bus.req_conn & ~connected;
  assign disc_vld  = bus.req_disc & connected;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (conn_elig),
    .ptr     (rr_ptr),
    .win     (win),
    .win_idx (win_idx),
    .valid   (win_vld)
  );

  // Capacity is judged on the registered count, so freed slots wait a cycle.
  assign grant     = win_vld && (conn_cnt < MAX_CNT);
  assign conn_next = (connected & ~disc_vld) | (grant ? win : '0);
  assign cnt_next  = conn_cnt - CNT_W'(popcount(POP_W'(disc_vld))) + CNT_W'(grant);
  assign ptr_next  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      connected <= '0;
      gnt       <= '0;
      conn_cnt  <= '0;
      rr_ptr    <= '0;
      state     <= EMPTY;
    end else begin
      connected <= conn_next;
      gnt       <= grant ? win : '0;
      conn_cnt  <= cnt_next;
      state     <= state_of(cnt_next);
      if (grant) begin
        rr_ptr <= ptr_next;
      end
    end
  end

  assign bus.gnt        = gnt;
  assign bus.connected  = connected;
  assign bus.conn_cnt   = conn_cnt;
  assign bus.slot_avail = (conn_cnt < MAX_CNT);
  assign bus.full       = (conn_cnt == MAX_CNT);

  a_state_matches_cnt : assert property (
    @(posedge clk) disable iff (!rst_n) state == state_of(conn_cnt)
  );

`ifdef SERVER_ARB_STATS_EN
  logic [15:0]      deny_cnt;
  logic [CNT_W-1:0] peak_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deny_cnt <= '0;
      peak_cnt <= '0;
    end else begin
      if (state == FULL && |conn_elig && deny_cnt != '1) begin
        deny_cnt <= deny_cnt + 1'b1;
      end
      if (cnt_next > peak_cnt) begin
        peak_cnt <= cnt_next;
      end
    end
  end

  assign bus.deny_cnt = deny_cnt;
  assign bus.peak_cnt = peak_cnt;
`endif

endmodule
